// File: rtl/pmod_dac_spi_if.sv
// Sample handshake between the CORDIC generator and the PMOD DAC serialiser.
// The producer drives a signed sample with valid; the serialiser answers with ready.
interface pmod_dac_spi_if #(
    parameter int width = 16
);
    logic signed [width-1:0] datain;
    logic                    valid;
    logic                    ready;

    modport master (
        output datain,
        output valid,
        input  ready
    );

    modport slave (
        input  datain,
        input  valid,
        output ready
    );
endinterface

// File: rtl/pmod_dac_spi.sv
// PMOD DAC output stage: converts one signed CORDIC sample to 12-bit offset
// binary and shifts it out MSB first as a 16-bit SYNC/SCLK/DIN frame.
// SCLK idles high; the DAC samples DIN on each falling SCLK edge, and DIN
// moves on the rising edges so every bit is centred on its sampling edge.
module pmod_dac_spi #(
    parameter int width      = 16,
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic           clock,
    input  logic           resetn,
    pmod_dac_spi_if.slave  sample_if,
    output logic           cs,
    output logic           sclk,
    output logic           sdata,
    output logic           done
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t           state, state_d;
    logic             cs_d, sclk_d, sdata_d, done_d;
    logic             ready_r, ready_d;
    logic [3:0]       bitcnt, bitcnt_d;
    logic [DIV_W-1:0] divcnt, divcnt_d;
    logic [GAP_W-1:0] gapcnt, gapcnt_d;
    logic             load;
    logic [15:0]      frame_in;
    logic [15:0]      frame_p0;

    // Top 12 bits of the signed sample with the sign flipped: two's complement
    // becomes offset binary, so full-scale negative maps to code 0.
    function automatic logic [11:0] to_offset_binary(input logic signed [11:0] top);
        return {~top[11], top[10:0]};
    endfunction

    // Bits below the DAC resolution are dropped on purpose.
    if (width > 12) begin : g_lsb_drop
        wire unused_lsbs = ^sample_if.datain[width-13:0];
    end

    // Upper nibble is the DAC control field; 00 keeps it in normal operation.
    assign frame_in        = {4'b0000, to_offset_binary(sample_if.datain[width-1 -: 12])};
    assign sample_if.ready = ready_r;

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d  = state;
        cs_d     = cs;
        sclk_d   = sclk;
        sdata_d  = sdata;
        done_d   = 1'b0;
        ready_d  = ready_r;
        bitcnt_d = bitcnt;
        divcnt_d = divcnt;
        gapcnt_d = gapcnt;
        load     = 1'b0;
        unique case (state)
            IDLE: begin
                if (sample_if.valid && ready_r) begin
                    load     = 1'b1;
                    state_d  = SHIFT;
                    cs_d     = 1'b0;
                    sclk_d   = 1'b1;
                    sdata_d  = frame_in[15];
                    bitcnt_d = 4'd15;
                    divcnt_d = '0;
                    ready_d  = 1'b0;
                end
            end
            SHIFT: begin
                if (divcnt == DIV_LAST) begin
                    divcnt_d = '0;
                    sclk_d   = ~sclk;
                    // Only the rising SCLK toggle advances the data; the
                    // falling toggle is where the DAC samples it.
                    if (!sclk) begin
                        if (bitcnt != 4'd0) begin
                            bitcnt_d = bitcnt - 4'd1;
                            sdata_d  = frame_p0[bitcnt - 4'd1];
                        end else begin
                            cs_d     = 1'b1;
                            sdata_d  = 1'b0;
                            done_d   = 1'b1;
                            gapcnt_d = '0;
                            state_d  = GAP;
                        end
                    end
                end else begin
                    divcnt_d = divcnt + DIV_W'(1);
                end
            end
            GAP: begin
                if (gapcnt == GAP_LAST) begin
                    state_d = IDLE;
                    ready_d = 1'b1;
                end else begin
                    gapcnt_d = gapcnt + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cs_d    = 1'b1;
                sclk_d  = 1'b1;
                sdata_d = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    // Control state and SPI pins; reset abandons any frame in flight.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            cs     <= 1'b1;
            sclk   <= 1'b1;
            sdata  <= 1'b0;
            done   <= 1'b0;
            ready_r <= 1'b1;
            bitcnt <= '0;
            divcnt <= '0;
            gapcnt <= '0;
        end else begin
            state  <= state_d;
            cs     <= cs_d;
            sclk   <= sclk_d;
            sdata  <= sdata_d;
            done   <= done_d;
            ready_r <= ready_d;
            bitcnt <= bitcnt_d;
            divcnt <= divcnt_d;
            gapcnt <= gapcnt_d;
        end
    end

    // Stage p0: frame captured at accept and frozen for the whole transfer.
    always_ff @(posedge clock) begin
        if (load) begin
            frame_p0 <= frame_in;
        end
    end
endmodule

// File: tb/tb_pmod_dac_spi.sv
// Bench for pmod_dac_spi: two instances (CLK_DIV=2/GAP=2 and CLK_DIV=1/GAP=1),
// a timeline reference model, an SPI decoder and a table of conversion vectors.
module tb_pmod_dac_spi;
    localparam int W     = 16;
    localparam int DIV_A = 2;
    localparam int GAP_A = 2;
    localparam int DIV_B = 1;
    localparam int GAP_B = 1;

    logic       clock;
    logic       resetn;
    logic [1:0] cs_v, sclk_v, sdata_v, done_v;

    pmod_dac_spi_if #(.width(W)) if_a ();
    pmod_dac_spi_if #(.width(W)) if_b ();

    pmod_dac_spi #(.width(W), .CLK_DIV(DIV_A), .GAP_CYCLES(GAP_A)) dut_a (
        .clock(clock), .resetn(resetn), .sample_if(if_a),
        .cs(cs_v[0]), .sclk(sclk_v[0]), .sdata(sdata_v[0]), .done(done_v[0])
    );

    pmod_dac_spi #(.width(W), .CLK_DIV(DIV_B), .GAP_CYCLES(GAP_B)) dut_b (
        .clock(clock), .resetn(resetn), .sample_if(if_b),
        .cs(cs_v[1]), .sclk(sclk_v[1]), .sdata(sdata_v[1]), .done(done_v[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, req);
    endtask

    // Offset-binary code from plain arithmetic: shift range to 0..65535, keep top 12 bits.
    function automatic logic [11:0] ref_code(input logic [15:0] s);
        logic signed [15:0] ss;
        int v;
        ss = s;
        v  = int'(ss);
        return 12'((v + 32768) / 16);
    endfunction

    // Reference model: age = cycles since accept (-1 when idle).
    int          age[2];
    bit          mrdy[2];
    logic [11:0] cur_code[2];
    int          acc_cnt[2];
    // SPI decoder state.
    int          frames[2];
    int          done_cnt[2];
    int          spacing[2];
    int          last_fall[2];
    int          low_start[2];
    int          nbits[2];
    logic [15:0] sh[2];
    logic        prev_cs[2];
    logic        prev_sclk[2];
    logic [15:0] dec_q0[$];
    int          cyc = 0;

    task automatic step(input int d);
        int          dv, gp, b;
        logic        v, rdy;
        logic [15:0] din;
        logic [4:0]  req, act;
        dv  = (d == 0) ? DIV_A : DIV_B;
        gp  = (d == 0) ? GAP_A : GAP_B;
        v   = (d == 0) ? if_a.valid : if_b.valid;
        din = (d == 0) ? if_a.datain : if_b.datain;
        rdy = (d == 0) ? if_a.ready : if_b.ready;

        if (!resetn) begin
            age[d]  = -1;
            mrdy[d] = 1'b1;
        end else if (mrdy[d] && v) begin
            age[d]      = 0;
            mrdy[d]     = 1'b0;
            cur_code[d] = ref_code(din);
            acc_cnt[d]++;
        end else if (age[d] >= 0) begin
            age[d]++;
            if (age[d] == 32 * dv + gp) begin
                age[d]  = -1;
                mrdy[d] = 1'b1;
            end
        end

        // Expected {cs, sclk, sdata, done, ready} after this edge.
        if (age[d] < 0) begin
            req = 5'b11001;
        end else if (age[d] < 32 * dv) begin
            b = 15 - age[d] / (2 * dv);
            req = {1'b0, ((age[d] / dv) % 2 == 0), (b < 12) ? cur_code[d][b] : 1'b0, 1'b0, 1'b0};
        end else begin
            req = {1'b1, 1'b1, 1'b0, (age[d] == 32 * dv), 1'b0};
        end
        act = {cs_v[d], sclk_v[d], sdata_v[d], done_v[d], rdy};
        check($sformatf("outputs_d%0d_c%0d", d, cyc), 32'(act), 32'(req));

        if (!resetn) begin
            nbits[d]     = 0;
            prev_cs[d]   = 1'b1;
            prev_sclk[d] = 1'b1;
            last_fall[d] = -1;
        end else begin
            if (prev_cs[d] && !cs_v[d]) begin
                if (last_fall[d] >= 0) spacing[d] = cyc - last_fall[d];
                last_fall[d] = cyc;
                low_start[d] = cyc;
                nbits[d]     = 0;
                sh[d]        = '0;
            end
            if (!cs_v[d] && prev_sclk[d] && !sclk_v[d]) begin
                sh[d] = {sh[d][14:0], sdata_v[d]};
                nbits[d]++;
            end
            if (!prev_cs[d] && cs_v[d]) begin
                frames[d]++;
                check($sformatf("frame_bits_d%0d", d), 32'(nbits[d]), 32'd16);
                check($sformatf("frame_value_d%0d", d), 32'(sh[d]), 32'({4'b0000, cur_code[d]}));
                check($sformatf("cs_low_len_d%0d", d), 32'(cyc - low_start[d]), 32'(32 * dv));
                if (d == 0) dec_q0.push_back(sh[d]);
            end
            prev_cs[d]   = cs_v[d];
            prev_sclk[d] = sclk_v[d];
        end
        done_cnt[d] += int'(done_v[d]);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            cyc++;
            step(0);
            step(1);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    task automatic send(input int d, input logic [15:0] din);
        if (d == 0) begin if_a.datain = din; if_a.valid = 1'b1; end
        else        begin if_b.datain = din; if_b.valid = 1'b1; end
        @(negedge clock);
        if (d == 0) if_a.valid = 1'b0;
        else        if_b.valid = 1'b0;
    endtask

    task automatic get_frame_a(input string name, input logic [11:0] code);
        int t = 0;
        while (dec_q0.size() == 0 && t < 400) begin
            @(negedge clock);
            t++;
        end
        if (dec_q0.size() == 0) check({name, "_timeout"}, 32'd0, 32'd1);
        else check(name, 32'(dec_q0.pop_front()), 32'({4'b0000, code}));
    endtask

    task automatic wait_acc(input int d, input int ac);
        int t = 0;
        while (acc_cnt[d] == ac && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (acc_cnt[d] == ac) check($sformatf("accept_timeout_d%0d", d), 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [15:0] din;
        logic [11:0] code;
    } vec_t;

    vec_t        tbl[7];
    logic [15:0] ext_din[3];
    logic [11:0] ext_code[3];
    int          dc, fr, ac;

    initial begin
        tbl[0] = '{16'h4000, 12'hC00};
        tbl[1] = '{16'h0000, 12'h800};
        tbl[2] = '{16'h7FFF, 12'hFFF};
        tbl[3] = '{16'h8000, 12'h000};
        tbl[4] = '{16'hFFF0, 12'h7FF};
        tbl[5] = '{16'hC000, 12'h400};
        tbl[6] = '{16'h1230, 12'h923};
        ext_din  = '{16'h7FFF, 16'h8000, 16'h0000};
        ext_code = '{12'hFFF, 12'h000, 12'h800};

        for (int d = 0; d < 2; d++) begin
            age[d] = -1; mrdy[d] = 1'b1; acc_cnt[d] = 0; frames[d] = 0; done_cnt[d] = 0;
            spacing[d] = 0; last_fall[d] = -1; low_start[d] = 0; nbits[d] = 0; sh[d] = '0;
            prev_cs[d] = 1'b1; prev_sclk[d] = 1'b1; cur_code[d] = '0;
        end
        if_a.valid = 1'b0; if_a.datain = '0;
        if_b.valid = 1'b0; if_b.datain = '0;
        resetn = 1'b1;
        #2 resetn = 1'b0;

        // Reset then idle.
        repeat (5) @(negedge clock);
        resetn = 1'b1;
        repeat (100) @(negedge clock);
        check("idle_a", 32'({cs_v[0], sclk_v[0], sdata_v[0], done_v[0], if_a.ready}), 32'h19);
        check("idle_b", 32'({cs_v[1], sclk_v[1], sdata_v[1], done_v[1], if_b.ready}), 32'h19);

        // Conversion table, one isolated frame each.
        for (int i = 0; i < 7; i++) begin
            dc = done_cnt[0];
            send(0, tbl[i].din);
            get_frame_a($sformatf("table_%0d_%h", i, tbl[i].din), tbl[i].code);
            repeat (4) @(negedge clock);
            check($sformatf("table_done_once_%0d", i), 32'(done_cnt[0] - dc), 32'd1);
        end

        // Extremes back-to-back with valid held high.
        if_a.datain = ext_din[0];
        if_a.valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if_a.datain = ext_din[k];
            ac = acc_cnt[0];
            wait_acc(0, ac);
            if (k > 0) check($sformatf("b2b_spacing_%0d", k), 32'(spacing[0]), 32'd67);
        end
        if_a.valid = 1'b0;
        for (int k = 0; k < 3; k++) get_frame_a($sformatf("b2b_code_%0d", k), ext_code[k]);
        repeat (5) @(negedge clock);

        // Busy-drop: a second sample offered mid-frame is ignored.
        send(0, 16'h1230);
        repeat (20) @(negedge clock);
        send(0, 16'hABC0);
        get_frame_a("busy_frame", 12'h923);
        fr = frames[0];
        repeat (100) @(negedge clock);
        check("busy_no_second_frame", 32'(frames[0]), 32'(fr));
        check("busy_ready_idle", 32'(if_a.ready), 32'd1);

        // Reset mid-frame while sclk is low during bit 7.
        send(0, 16'h5550);
        repeat (34) @(posedge clock);
        #2;
        check("pre_reset_sclk_low", 32'(sclk_v[0]), 32'd0);
        dc = done_cnt[0];
        fr = frames[0];
        #1 resetn = 1'b0;
        #1;
        check("async_cs", 32'(cs_v[0]), 32'd1);
        check("async_sclk", 32'(sclk_v[0]), 32'd1);
        check("async_sdata", 32'(sdata_v[0]), 32'd0);
        check("async_ready", 32'(if_a.ready), 32'd1);
        repeat (3) @(negedge clock);
        resetn = 1'b1;
        repeat (10) @(negedge clock);
        check("reset_no_done", 32'(done_cnt[0]), 32'(dc));
        check("reset_no_frame", 32'(frames[0]), 32'(fr));
        check("reset_queue_empty", 32'(dec_q0.size()), 32'd0);
        send(0, 16'hC000);
        get_frame_a("after_reset_code", 12'h400);
        repeat (5) @(negedge clock);

        // Random traffic on both instances, checked cycle by cycle by the model.
        for (int c = 0; c < 800; c++) begin
            if_a.valid  = ($urandom_range(0, 3) == 0);
            if_a.datain = 16'($urandom);
            if_b.valid  = ($urandom_range(0, 2) == 0);
            if_b.datain = 16'($urandom);
            @(negedge clock);
        end
        if_a.valid = 1'b0;
        if_b.valid = 1'b0;
        repeat (100) @(negedge clock);
        dec_q0.delete();

        // CLK_DIV=1, GAP_CYCLES=1 with continuous valid.
        if_b.datain = 16'($urandom);
        if_b.valid  = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ac = acc_cnt[1];
            wait_acc(1, ac);
            if_b.datain = 16'($urandom);
            if (k > 0) check($sformatf("fast_spacing_%0d", k), 32'(spacing[1]), 32'd34);
        end
        if_b.valid = 1'b0;
        repeat (50) @(negedge clock);
        check("fast_frames_seen", 32'(frames[1] > 0), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
